dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of the data-memory byte address.
REQ-002 The block SHALL have port clock_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0_i / req1_i, input, 1 bit each: lane 0 / lane 1 memory-stage bundle requests a data-memory access.
REQ-005 The block SHALL have ports we0_i / we1_i, input, 1 bit each: 1 = store, 0 = load.
REQ-006 The block SHALL have ports addr0_i / addr1_i, input, ADDR_W bits each: byte address.
REQ-007 The block SHALL have ports wdata0_i / wdata1_i, input, 32 bits each: store data.
REQ-008 The block SHALL have ports be0_i / be1_i, input, 4 bits each: byte enables.
REQ-009 The block SHALL have ports mem_req_o, mem_we_o, mem_addr_o[ADDR_W], mem_wdata_o[32], mem_be_o[4], all outputs: single shared data-memory port.
REQ-010 The block SHALL have port mem_ack_i, input, 1 bit: memory completes the current access this cycle.
REQ-011 The block SHALL have port mem_rdata_i, input, 32 bits: load data, valid when mem_ack_i=1.
REQ-012 The block SHALL have ports rdata0_o / rdata1_o, output, 32 bits each: last load result per lane.
REQ-013 The block SHALL have port stall_o, output, 1 bit: freeze the memory stage and all older stages.
REQ-014 The block SHALL have port done_o, output, 1 bit: one-cycle pulse, bundle accesses complete.

Function
REQ-015 The block SHALL implement FSM states IDLE, L0, L1 and DONE, held in registers.
REQ-016 IDLE: when req0_i|req1_i=1, the block SHALL latch req/we/addr/wdata/be of both lanes, then go to L0 if req0_i=1, else L1; otherwise it SHALL stay in IDLE.
REQ-017 mem_req_o SHALL be 1 exactly in L0 or L1, decoded from registered state only.
REQ-018 The mem_* fields SHALL come from the latched lane-0 copy in L0 and the latched lane-1 copy in L1, and SHALL be stable until ack.
REQ-019 In L0 or L1 with mem_ack_i=0, the state and all mem_* outputs SHALL hold; there is no timeout.
REQ-020 L0 with mem_ack_i=1: if the latched we0=0, the block SHALL load rdata0_o<=mem_rdata_i; next state SHALL be L1 if the latched req1=1, else DONE.
REQ-021 L1 with mem_ack_i=1: if the latched we1=0, the block SHALL load rdata1_o<=mem_rdata_i; next state SHALL be DONE.
REQ-022 Lane 0 SHALL always be serviced before lane 1 (program order), including when both lanes target the same address.
REQ-023 DONE: done_o SHALL be 1, stall_o SHALL be 0, inputs SHALL NOT be sampled, and the next state SHALL be IDLE unconditionally.
REQ-024 stall_o SHALL be (IDLE & (req0_i|req1_i)) | L0 | L1; it is combinational on the req inputs in IDLE only.
REQ-025 rdata0_o/rdata1_o SHALL change only on a load ack for their own lane; stores and idle cycles SHALL leave them unchanged.
REQ-026 mem_ack_i SHALL be ignored in IDLE and DONE.
REQ-027 Minimum latency SHALL be 3 cycles from a sampled request to the done_o cycle for a single-lane access with ack in the first mem_req_o cycle, and 4 cycles for a dual-lane access.
REQ-028 mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o SHALL be 0 when mem_req_o=0.

Reset
REQ-029 On reset_i=1 at a clock edge, the block SHALL set state=IDLE, all latched lane registers=0, rdata0_o=rdata1_o=0, so mem_req_o=0 and done_o=0 next cycle.
REQ-030 Reset SHALL take priority over every transition, including mid-L0/L1 with mem_ack_i=1; that ack SHALL be discarded and rdata SHALL NOT update.
REQ-031 While reset_i=1, stall_o SHALL still follow REQ-024 with state=IDLE.

Verification
REQ-032 Lane-0 load only: req0=1,we0=0,addr0=0x100, ack on first mem_req cycle with rdata=0xDEADBEEF -> mem_req 1 cycle at addr 0x100, rdata0_o=0xDEADBEEF, done_o on cycle 3, rdata1_o unchanged.
REQ-033 Dual: lane0 store 0x11223344 @0x200 be=0xF, lane1 load @0x200 returning 0x11223344 -> store issued first, then load, done_o on cycle 4, rdata1_o=0x11223344.
REQ-034 Lane-1 only, ack delayed 3 cycles -> L0 skipped, mem_req_o held 4 cycles with stable addr, stall_o high throughout, then done_o.
REQ-035 Back-to-back bundles: second bundle presented in the done_o cycle -> not sampled in DONE; sampled in the following IDLE cycle.
REQ-036 reset_i asserted in L1 with mem_ack_i=1, rdata=0xCAFEF00D -> next cycle IDLE, mem_req_o=0, rdata1_o=0, done_o never pulses.
REQ-037 Idle: req0=req1=0 for 10 cycles with spurious mem_ack_i=1 -> stall_o=0, mem_req_o=0, rdata outputs unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares one data-memory port between the two memory-stage
// lanes of a dual-issue pipeline. A bundle is captured in IDLE. Lane 0 is
// then serviced before lane 1, so same-address store/load pairs keep program
// order. The pipeline is stalled until every access of the bundle has been
// acknowledged.
//
// Ports
//   clock_i, reset_i          : clock, synchronous active-high reset
//   req0_i/req1_i             : lane request
//   we0_i/we1_i               : 1 = store, 0 = load
//   addr0_i/addr1_i           : byte address
//   wdata0_i/wdata1_i         : store data
//   be0_i/be1_i               : byte enables
//   mem_req_o ... mem_be_o    : shared memory port (fields zero when idle)
//   mem_ack_i, mem_rdata_i    : access completion and load data
//   rdata0_o/rdata1_o         : last load result per lane
//   stall_o                   : freeze memory stage and older stages
//   done_o                    : one-cycle pulse when the bundle completes
module dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  input  logic [3:0]        be0_i,
  input  logic [3:0]        be1_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       rdata0_o,
  output logic [31:0]       rdata1_o,
  output logic              stall_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_t;

  state_t state, state_next;

  // Lane 0's request only chooses the first state out of IDLE, so lane 1's
  // request is the only one that has to be kept.
  logic              req1_q;
  logic              we0_q, we1_q;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic [31:0]       wdata0_q, wdata1_q;
  logic [3:0]        be0_q, be1_q;

  logic bundle_start;
  assign bundle_start = (state == IDLE) && (req0_i || req1_i);

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every output of this block gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req0_i || req1_i) state_next = req0_i ? L0 : L1;
      L0:   if (mem_ack_i) state_next = req1_q ? L1 : DONE;
      L1:   if (mem_ack_i) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory port is decoded from registered state only; fields are forced to
  // zero whenever no access is in flight.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    case (state)
      L0: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we0_q;
        mem_addr_o  = addr0_q;
        mem_wdata_o = wdata0_q;
        mem_be_o    = be0_q;
      end
      L1: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we1_q;
        mem_addr_o  = addr1_q;
        mem_wdata_o = wdata1_q;
        mem_be_o    = be1_q;
      end
      default: ;
    endcase
  end

  // Stall is raised in the sampling cycle itself so the pipeline never
  // advances past a bundle that has not been accepted.
  assign stall_o = bundle_start || (state == L0) || (state == L1);
  assign done_o  = (state == DONE);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      req1_q   <= 1'b0;
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      be0_q    <= '0;
      be1_q    <= '0;
      rdata0_o <= '0;
      rdata1_o <= '0;
    end else begin
      if (bundle_start) begin
        req1_q   <= req1_i;
        we0_q    <= we0_i;
        we1_q    <= we1_i;
        addr0_q  <= addr0_i;
        addr1_q  <= addr1_i;
        wdata0_q <= wdata0_i;
        wdata1_q <= wdata1_i;
        be0_q    <= be0_i;
        be1_q    <= be1_i;
      end
      // Load results land only on the acknowledging cycle of their own lane.
      if ((state == L0) && mem_ack_i && !we0_q) rdata0_o <= mem_rdata_i;
      if ((state == L1) && mem_ack_i && !we1_q) rdata1_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- directed scenarios plus randomized bundles. Expected
// behaviour comes from a transaction-level model: a bundle is an ordered list
// of lane accesses (lane 0 first), each answered after a chosen number of
// wait cycles, and the per-lane load results are tracked as plain variables.
module tb_dmem_arbiter;

  localparam int AW = 32;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          req0_i, req1_i, we0_i, we1_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [31:0]   wdata0_i, wdata1_i;
  logic [3:0]    be0_i, be1_i;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;
  logic [31:0]   rdata0_o, rdata1_o;
  logic          stall_o, done_o;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .be0_i(be0_i), .be1_i(be1_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .stall_o(stall_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    bit          req[2];
    bit          we[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic [3:0]  be[2];
    int          wait_cycles[2];
    logic [31:0] rdata[2];
  } bundle_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_rd[2];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_port_quiet(input string tag);
    check({tag, "_mem_req"},   {31'd0, mem_req_o}, 32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we_o},  32'd0);
    check({tag, "_mem_addr"},  mem_addr_o,         32'd0);
    check({tag, "_mem_wdata"}, mem_wdata_o,        32'd0);
    check({tag, "_mem_be"},    {28'd0, mem_be_o},  32'd0);
  endtask

  task automatic check_rdata(input string tag);
    check({tag, "_rdata0"}, rdata0_o, exp_rd[0]);
    check({tag, "_rdata1"}, rdata1_o, exp_rd[1]);
  endtask

  task automatic drive_bundle(input bundle_t b);
    req0_i = b.req[0];   req1_i = b.req[1];
    we0_i = b.we[0];     we1_i = b.we[1];
    addr0_i = b.addr[0]; addr1_i = b.addr[1];
    wdata0_i = b.wdata[0]; wdata1_i = b.wdata[1];
    be0_i = b.be[0];     be1_i = b.be[1];
  endtask

  // Clears the requests and scrambles the other lane inputs so that any use
  // of unlatched inputs shows up on the memory port.
  task automatic drop_inputs();
    req0_i = 1'b0; req1_i = 1'b0;
    we0_i = 1'($urandom); we1_i = 1'($urandom);
    addr0_i = $urandom; addr1_i = $urandom;
    wdata0_i = $urandom; wdata1_i = $urandom;
    be0_i = 4'($urandom); be1_i = 4'($urandom);
  endtask

  // Entered at a negedge while the DUT is in IDLE (in_done=0) or in the
  // DONE cycle of the previous bundle (in_done=1). Returns at the negedge of
  // this bundle's DONE cycle with requests dropped.
  task automatic run_bundle(input bundle_t b, input bit in_done);
    drive_bundle(b);
    mem_ack_i   = 1'($urandom);  // spurious: must be ignored in IDLE/DONE
    mem_rdata_i = $urandom;
    #1;
    if (in_done) begin
      check("b2b_in_done_done",  {31'd0, done_o},  32'd1);
      check("b2b_in_done_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clock_i);
      mem_ack_i = 1'($urandom);
      #1;
      check("b2b_idle_mem_req", {31'd0, mem_req_o}, 32'd0);
      check("b2b_idle_done",    {31'd0, done_o},    32'd0);
    end
    check("sample_stall",   {31'd0, stall_o},   32'd1);
    check("sample_mem_req", {31'd0, mem_req_o}, 32'd0);
    @(negedge clock_i);
    drop_inputs();
    for (int lane = 0; lane < 2; lane++) begin
      if (b.req[lane]) begin
        for (int k = 0; k <= b.wait_cycles[lane]; k++) begin
          check("acc_mem_req", {31'd0, mem_req_o},   32'd1);
          check("acc_mem_we",  {31'd0, mem_we_o},    {31'd0, b.we[lane]});
          check("acc_addr",    mem_addr_o,           b.addr[lane]);
          check("acc_wdata",   mem_wdata_o,          b.wdata[lane]);
          check("acc_be",      {28'd0, mem_be_o},    {28'd0, b.be[lane]});
          check("acc_stall",   {31'd0, stall_o},     32'd1);
          check("acc_done",    {31'd0, done_o},      32'd0);
          check_rdata("acc");
          mem_ack_i   = (k == b.wait_cycles[lane]);
          mem_rdata_i = mem_ack_i ? b.rdata[lane] : $urandom;
          @(negedge clock_i);
        end
        if (!b.we[lane]) exp_rd[lane] = b.rdata[lane];
        mem_ack_i = 1'b0;
      end
    end
    check("done_pulse", {31'd0, done_o},  32'd1);
    check("done_stall", {31'd0, stall_o}, 32'd0);
    check_port_quiet("done");
    check_rdata("done");
  endtask

  function automatic bundle_t mk(input bit r0, input bit w0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic [3:0] e0,
                                 input int c0, input logic [31:0] q0,
                                 input bit r1, input bit w1, input logic [31:0] a1,
                                 input logic [31:0] d1, input logic [3:0] e1,
                                 input int c1, input logic [31:0] q1);
    bundle_t b;
    b.req[0] = r0; b.we[0] = w0; b.addr[0] = a0; b.wdata[0] = d0;
    b.be[0] = e0; b.wait_cycles[0] = c0; b.rdata[0] = q0;
    b.req[1] = r1; b.we[1] = w1; b.addr[1] = a1; b.wdata[1] = d1;
    b.be[1] = e1; b.wait_cycles[1] = c1; b.rdata[1] = q1;
    return b;
  endfunction

  initial begin
    bundle_t b;
    bit      b2b;
    int      lanes;

    // Reset, with a request held high while reset is asserted.
    reset_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = '0;
    drop_inputs();
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clock_i);
    check_port_quiet("reset");
    check("reset_done",  {31'd0, done_o},  32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check_rdata("reset");
    req0_i = 1'b1;
    #1 check("reset_stall_req", {31'd0, stall_o}, 32'd1);
    @(negedge clock_i);
    check("reset_hold_mem_req", {31'd0, mem_req_o}, 32'd0);
    req0_i = 1'b0; reset_i = 1'b0;
    @(negedge clock_i);

    // Lane-0 load only, ack on the first request cycle.
    run_bundle(mk(1, 0, 32'h100, 32'h0, 4'hF, 0, 32'hDEADBEEF,
                  0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0), 0);
    @(negedge clock_i);

    // Lane-0 store then lane-1 load of the same address.
    run_bundle(mk(1, 1, 32'h200, 32'h11223344, 4'hF, 0, 32'h0,
                  1, 0, 32'h200, 32'h0, 4'hF, 0, 32'h11223344), 0);
    @(negedge clock_i);

    // Lane-1 only with ack delayed three cycles.
    run_bundle(mk(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,
                  1, 0, 32'h340, 32'h0, 4'h3, 3, 32'hA5A5_0F0F), 0);

    // Second bundle presented during the DONE pulse.
    run_bundle(mk(1, 0, 32'h44, 32'h0, 4'hC, 1, 32'h1234_5678,
                  1, 1, 32'h48, 32'h9999_0000, 4'h1, 0, 32'h0), 1);
    @(negedge clock_i);

    // Reset while lane 1 is being acknowledged.
    drive_bundle(mk(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,
                    1, 0, 32'h80, 32'h0, 4'hF, 0, 32'h0));
    @(negedge clock_i);
    drop_inputs();
    check("rst_mid_mem_req", {31'd0, mem_req_o}, 32'd1);
    check("rst_mid_addr",    mem_addr_o,         32'h80);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; reset_i = 1'b1;
    @(negedge clock_i);
    exp_rd[0] = '0; exp_rd[1] = '0;
    reset_i = 1'b0; mem_ack_i = 1'b0;
    check_port_quiet("rst_mid");
    check("rst_mid_done", {31'd0, done_o}, 32'd0);
    check_rdata("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_i);
      check("rst_after_done", {31'd0, done_o}, 32'd0);
    end

    // Give rdata non-zero values, then idle with spurious acks.
    run_bundle(mk(1, 0, 32'h10, 32'h0, 4'hF, 0, 32'h0BAD_F00D,
                  1, 0, 32'h14, 32'h0, 4'hF, 2, 32'hFEED_FACE), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_i);
      mem_ack_i = 1'b1; mem_rdata_i = $urandom;
      #1;
      check("idle_stall", {31'd0, stall_o}, 32'd0);
      check_port_quiet("idle");
      check_rdata("idle");
    end
    mem_ack_i = 1'b0;
    @(negedge clock_i);

    // Randomized bundles.
    for (int n = 0; n < 60; n++) begin
      lanes = $urandom_range(1, 3);
      for (int l = 0; l < 2; l++) begin
        b.req[l]         = lanes[l];
        b.we[l]          = 1'($urandom);
        b.addr[l]        = $urandom;
        b.wdata[l]       = $urandom;
        b.be[l]          = 4'($urandom);
        b.wait_cycles[l] = $urandom_range(0, 3);
        b.rdata[l]       = $urandom;
      end
      if ($urandom_range(0, 3) == 0) b.addr[1] = b.addr[0];
      b2b = (n > 0) && ($urandom_range(0, 2) == 0);
      if (!b2b && n > 0) @(negedge clock_i);
      run_bundle(b, b2b);
    end
    @(negedge clock_i);
    check("final_done", {31'd0, done_o}, 32'd0);
    check_rdata("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
